// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the frame streamer.
//   state_t    - streamer control states
//   hann_coeff - Hann window coefficient generator, evaluated at elaboration
//                to build the coefficient ROM contents
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam real PI = 3.14159265358979323846;

  // coeff[n] = round((2^coeff_w - 1) * 0.5 * (1 - cos(2*pi*n/(N-1)))), N = 2^addr_w
  function automatic logic [31:0] hann_coeff(input int unsigned n,
                                             input int unsigned addr_w,
                                             input int unsigned coeff_w);
    real         full_scale;
    real         phase;
    int unsigned len;
    full_scale = 1.0;
    for (int unsigned i = 0; i < coeff_w; i++) begin
      full_scale = full_scale * 2.0;
    end
    full_scale = full_scale - 1.0;
    len        = 32'd1 << addr_w;
    phase      = 2.0 * PI * real'(n) / real'(len - 1);
    return 32'($rtoi(full_scale * 0.5 * (1.0 - $cos(phase)) + 0.5));
  endfunction

endpackage

// File: rtl/hann_coeff_rom.sv
// hann_coeff_rom: synchronous Hann coefficient ROM with 1-cycle read latency,
// matching the sample BRAM so coefficient and sample arrive together.
//   clk   - clock
//   idx   - coefficient index (sample position within the frame)
//   coeff - unsigned coefficient, valid one cycle after idx
module hann_coeff_rom
  import frame_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned COEFF_W = 24
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  idx,
  output logic [COEFF_W-1:0] coeff
);

  localparam int unsigned N = 32'd1 << ADDR_W;

  logic [31:0]        rom_w [N];
  logic [COEFF_W-1:0] coeff_q, coeff_d;

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom_w[g] = hann_coeff(g, ADDR_W, COEFF_W);
  end

  always_comb begin
    coeff_d = COEFF_W'(rom_w[idx]);
  end

  always_ff @(posedge clk) begin
    coeff_q <= coeff_d;
  end

  assign coeff = coeff_q;

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: reads one frame of offset-binary samples from a circular
// BRAM starting at the write head, converts to signed, optionally applies a
// Hann window and streams the result over an AXI-Stream master.
//   clk, rst        - clock, asynchronous active-high reset
//   head            - BRAM write pointer, captured on accepted start
//   start           - single-cycle frame request
//   window_en       - 1 = Hann, 0 = rectangular, captured on accepted start
//   addr, rd_en     - BRAM read port (1-cycle latency)
//   data            - BRAM read data
//   last_missing    - FFT core abort
//   m_tdata/tvalid/tlast/tready - AXI-Stream master, imag (upper half) = 0
//   busy            - frame in progress
//   overrun         - one-cycle pulse after a start that arrived while busy
module frame_streamer
  import frame_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COEFF_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   head,
  input  logic                start,
  input  logic                window_en,
  output logic [ADDR_W-1:0]   addr,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   data,
  input  logic                last_missing,
  output logic [2*DATA_W-1:0] m_tdata,
  output logic                m_tvalid,
  output logic                m_tlast,
  input  logic                m_tready,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned PROD_W = DATA_W + COEFF_W + 1;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic                     last;
  } beat_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   issue_q, issue_d;
  logic [ADDR_W-1:0] send_q, send_d;
  logic              win_q, win_d;
  logic              pend_q, pend_d;
  logic              pend_last_q, pend_last_d;
  beat_t             fifo_q [2];
  beat_t             fifo_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              overrun_q, overrun_d;

  logic [COEFF_W-1:0]       coeff;
  logic signed [DATA_W-1:0] s;
  logic signed [PROD_W-1:0] prod;
  beat_t                    push_beat;
  beat_t                    head_beat;
  logic [1:0]               occ;
  logic                     abort, pop, push, issue;

  hann_coeff_rom #(
    .ADDR_W (ADDR_W),
    .COEFF_W(COEFF_W)
  ) u_rom (
    .clk  (clk),
    .idx  (issue_q[ADDR_W-1:0]),
    .coeff(coeff)
  );

  // Datapath for the sample returning from the BRAM this cycle
  always_comb begin
    s              = {~data[DATA_W-1], data[DATA_W-2:0]};
    prod           = s * $signed({1'b0, coeff});
    push_beat.re   = win_q ? DATA_W'(prod >>> COEFF_W) : s;
    push_beat.last = pend_last_q;
  end

  always_comb begin
    busy      = (state_q != IDLE);
    abort     = last_missing && busy;
    head_beat = fifo_q[rd_ptr_q];
    m_tvalid  = (count_q != 2'd0);
    m_tdata   = m_tvalid ? {{DATA_W{1'b0}}, head_beat.re} : '0;
    m_tlast   = m_tvalid && head_beat.last;
    pop       = m_tvalid && m_tready;
    push      = pend_q && !abort;
    // Occupancy counts the slot freed by a beat leaving this cycle, so a
    // continuously ready sink sustains one read (and one beat) per cycle.
    occ       = 2'(pend_q) + count_q - 2'(pop);
    issue     = (state_q == STREAM) && !abort && !issue_q[ADDR_W] && (occ < 2'd2);
    rd_en     = issue;
    addr      = ptr_q;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    issue_d     = issue_q;
    send_d      = send_q;
    win_d       = win_q;
    pend_d      = issue;
    pend_last_d = issue && (issue_q[ADDR_W-1:0] == '1);
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + 2'(push) - 2'(pop);
    overrun_d   = start && busy;

    if (push) begin
      fifo_d[rd_ptr_q ^ count_q[0]] = push_beat;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      send_d   = send_q + 1'b1;
    end
    if (issue) begin
      ptr_d   = ptr_q + 1'b1;
      issue_d = issue_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = head;
          issue_d = '0;
          send_d  = '0;
          win_d   = window_en;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (issue_d[ADDR_W]) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (send_q == '1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d  = IDLE;
      pend_d   = 1'b0;
      count_d  = '0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      issue_q     <= '0;
      send_q      <= '0;
      win_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      fifo_q      <= '{default: '0};
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      issue_q     <= issue_d;
      send_q      <= send_d;
      win_q       <= win_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: directed self-checking bench for frame_streamer with
// ADDR_W=4 (16-point frames). BRAM model returns 0x8000+addr, or 0xFFFF for
// every address when all_ones is set.
module tb_frame_streamer;

  logic        clk;
  logic        rst;
  logic [3:0]  head;
  logic        start;
  logic        window_en;
  logic [3:0]  addr;
  logic        rd_en;
  logic [15:0] data;
  logic        last_missing;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        busy;
  logic        overrun;

  int unsigned total;
  int unsigned bad;

  logic        all_ones;
  logic [31:0] beat_data [32];
  logic        beat_last [32];
  int unsigned nbeats;
  int          busy_drop;
  int          first_valid;
  logic        busy_c1;
  logic        timed_out;
  int unsigned stable_err;
  logic        abort_tv;
  logic        abort_busy;
  logic        ovr_hist [64];

  frame_streamer #(
    .ADDR_W (4),
    .DATA_W (16),
    .COEFF_W(24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .head        (head),
    .start       (start),
    .window_en   (window_en),
    .addr        (addr),
    .rd_en       (rd_en),
    .data        (data),
    .last_missing(last_missing),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) data <= all_ones ? 16'hFFFF : (16'h8000 + {12'h000, addr});
  end

  // Runs one frame from the current cycle; collects accepted beats and timing.
  // bp: toggle m_tready 1,0,0,1. abort_after: assert last_missing after that
  // many beats (0 = never). ovr_at: cycle at which an extra start is sent.
  task automatic run_frame(input logic [3:0] h, input logic w, input logic bp,
                           input int unsigned abort_after, input int ovr_at);
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        lm_now;
    logic        check_abort;
    nbeats = 0; busy_drop = -1; first_valid = -1; timed_out = 1'b1;
    stable_err = 0; abort_tv = 1'b1; abort_busy = 1'b1; busy_c1 = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    lm_now = 1'b0; check_abort = 1'b0;
    for (int k = 0; k < 64; k++) ovr_hist[k] = 1'b0;
    head = h; window_en = w; start = 1'b1; m_tready = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == ovr_at);
      if (start) begin
        head = 4'd9;
        window_en = ~w;
      end
      m_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      last_missing = lm_now;
      if (lm_now) m_tready = 1'b0;
      #1;
      if (cyc < 64) ovr_hist[cyc] = overrun;
      if (cyc == 1) busy_c1 = busy;
      if (check_abort) begin
        abort_tv = m_tvalid;
        abort_busy = busy;
        timed_out = 1'b0;
        break;
      end
      if (last_missing) begin
        lm_now = 1'b0;
        check_abort = 1'b1;
        continue;
      end
      if (!busy) begin
        busy_drop = cyc;
        timed_out = 1'b0;
        break;
      end
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
        stable_err++;
      if (m_tvalid && first_valid < 0) first_valid = cyc;
      if (m_tvalid && m_tready) begin
        if (nbeats < 32) begin
          beat_data[nbeats] = m_tdata;
          beat_last[nbeats] = m_tlast;
        end
        nbeats++;
        if (nbeats == abort_after) lm_now = 1'b1;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
    end
    start = 1'b0; last_missing = 1'b0; m_tready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; head = '0; start = 1'b0; window_en = 1'b0;
    last_missing = 1'b0; m_tready = 1'b1; all_ones = 1'b0;
    #2;
    total++; if (addr !== 4'h0) begin bad++; $display("FAIL reset_addr: got %0h want 0", addr); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %0b want 0", rd_en); end
    total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %0h want 0", m_tdata); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %0b want 0", m_tvalid); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %0b want 0", m_tlast); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_rect;
    logic [31:0] exp_d;
    run_frame(4'd0, 1'b0, 1'b0, 0, -1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL rect_timeout: got %0b want 0", timed_out); end
    total++; if (nbeats != 16) begin bad++; $display("FAIL rect_count: got %0d want 16", nbeats); end
    total++; if (busy_c1 !== 1'b1) begin bad++; $display("FAIL rect_busy_c1: got %0b want 1", busy_c1); end
    total++; if (first_valid != 3) begin bad++; $display("FAIL rect_first_valid: got %0d want 3", first_valid); end
    total++; if (busy_drop != 19) begin bad++; $display("FAIL rect_busy_drop: got %0d want 19", busy_drop); end
    for (int i = 0; i < 16; i++) begin
      exp_d = 32'(i);
      total++; if (beat_data[i] !== exp_d) begin bad++; $display("FAIL rect_data[%0d]: got %0h want %0h", i, beat_data[i], exp_d); end
      total++; if (beat_last[i] !== (i == 15)) begin bad++; $display("FAIL rect_last[%0d]: got %0b want %0b", i, beat_last[i], (i == 15)); end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_wrap;
    logic [3:0]  e4;
    logic [31:0] exp_d;
    run_frame(4'd13, 1'b0, 1'b0, 0, -1);
    total++; if (nbeats != 16) begin bad++; $display("FAIL wrap_count: got %0d want 16", nbeats); end
    for (int i = 0; i < 16; i++) begin
      e4 = 4'(13 + i);
      exp_d = {28'h0, e4};
      total++; if (beat_data[i] !== exp_d) begin bad++; $display("FAIL wrap_data[%0d]: got %0h want %0h", i, beat_data[i], exp_d); end
      total++; if (beat_last[i] !== (i == 15)) begin bad++; $display("FAIL wrap_last[%0d]: got %0b want %0b", i, beat_last[i], (i == 15)); end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_hann;
    all_ones = 1'b1;
    run_frame(4'd0, 1'b1, 1'b0, 0, -1);
    all_ones = 1'b0;
    total++; if (nbeats != 16) begin bad++; $display("FAIL hann_count: got %0d want 16", nbeats); end
    total++; if (beat_data[0] !== 32'd0) begin bad++; $display("FAIL hann_b0: got %0d want 0", beat_data[0]); end
    total++; if (beat_data[1] !== 32'd1416) begin bad++; $display("FAIL hann_b1: got %0d want 1416", beat_data[1]); end
    total++; if (beat_data[7] !== 32'd32408) begin bad++; $display("FAIL hann_b7: got %0d want 32408", beat_data[7]); end
    total++; if (beat_data[8] !== 32'd32408) begin bad++; $display("FAIL hann_b8: got %0d want 32408", beat_data[8]); end
    total++; if (beat_data[15] !== 32'd0) begin bad++; $display("FAIL hann_b15: got %0d want 0", beat_data[15]); end
    total++; if (beat_last[15] !== 1'b1) begin bad++; $display("FAIL hann_last: got %0b want 1", beat_last[15]); end
    @(posedge clk); #2;
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_d;
    run_frame(4'd0, 1'b0, 1'b1, 0, -1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL bp_timeout: got %0b want 0", timed_out); end
    total++; if (nbeats != 16) begin bad++; $display("FAIL bp_count: got %0d want 16", nbeats); end
    total++; if (stable_err != 0) begin bad++; $display("FAIL bp_stable: got %0d want 0", stable_err); end
    for (int i = 0; i < 16; i++) begin
      exp_d = 32'(i);
      total++; if (beat_data[i] !== exp_d) begin bad++; $display("FAIL bp_data[%0d]: got %0h want %0h", i, beat_data[i], exp_d); end
    end
    total++; if (beat_last[15] !== 1'b1) begin bad++; $display("FAIL bp_last: got %0b want 1", beat_last[15]); end
    @(posedge clk); #2;
  endtask

  task automatic test_abort;
    logic [31:0] exp_d;
    run_frame(4'd3, 1'b0, 1'b0, 6, -1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL abort_timeout: got %0b want 0", timed_out); end
    total++; if (nbeats != 6) begin bad++; $display("FAIL abort_count: got %0d want 6", nbeats); end
    total++; if (abort_tv !== 1'b0) begin bad++; $display("FAIL abort_tvalid: got %0b want 0", abort_tv); end
    total++; if (abort_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", abort_busy); end
    run_frame(4'd0, 1'b0, 1'b0, 0, -1);
    total++; if (nbeats != 16) begin bad++; $display("FAIL after_abort_count: got %0d want 16", nbeats); end
    total++; if (busy_drop != 19) begin bad++; $display("FAIL after_abort_drop: got %0d want 19", busy_drop); end
    for (int i = 0; i < 16; i++) begin
      exp_d = 32'(i);
      total++; if (beat_data[i] !== exp_d) begin bad++; $display("FAIL after_abort_data[%0d]: got %0h want %0h", i, beat_data[i], exp_d); end
    end
    total++; if (beat_last[15] !== 1'b1) begin bad++; $display("FAIL after_abort_last: got %0b want 1", beat_last[15]); end
    @(posedge clk); #2;
  endtask

  task automatic test_overrun;
    logic [31:0] exp_d;
    run_frame(4'd0, 1'b0, 1'b0, 0, 5);
    total++; if (ovr_hist[5] !== 1'b0) begin bad++; $display("FAIL ovr_c5: got %0b want 0", ovr_hist[5]); end
    total++; if (ovr_hist[6] !== 1'b1) begin bad++; $display("FAIL ovr_c6: got %0b want 1", ovr_hist[6]); end
    total++; if (ovr_hist[7] !== 1'b0) begin bad++; $display("FAIL ovr_c7: got %0b want 0", ovr_hist[7]); end
    total++; if (nbeats != 16) begin bad++; $display("FAIL ovr_count: got %0d want 16", nbeats); end
    total++; if (busy_drop != 19) begin bad++; $display("FAIL ovr_busy_drop: got %0d want 19", busy_drop); end
    for (int i = 0; i < 16; i++) begin
      exp_d = 32'(i);
      total++; if (beat_data[i] !== exp_d) begin bad++; $display("FAIL ovr_data[%0d]: got %0h want %0h", i, beat_data[i], exp_d); end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_async_reset;
    head = 4'd2; window_en = 1'b0; start = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL arst_pre_tvalid: got %0b want 1", m_tvalid); end
    rst = 1'b1;
    #1;
    total++; if (addr !== 4'h0) begin bad++; $display("FAIL arst_addr: got %0h want 0", addr); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL arst_rd_en: got %0b want 0", rd_en); end
    total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL arst_tdata: got %0h want 0", m_tdata); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL arst_tvalid: got %0b want 0", m_tvalid); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL arst_tlast: got %0b want 0", m_tlast); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %0b want 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL arst_overrun: got %0b want 0", overrun); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_post_busy: got %0b want 0", busy); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_rect();
    test_wrap();
    test_hann();
    test_backpressure();
    test_abort();
    test_overrun();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
